// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer sitting between a simple read-only memory and
// a multi-cycle CPU core. For each instruction it issues a single read,
// waits for the word, hands it to the CPU (load strobe followed by start
// strobe) and then waits for the CPU to come back to its wait state before
// fetching the next word. A word whose top three bits are 3'b111 is a HALT:
// the unit parks in HALT until reset. If the CPU fails to return to its
// wait state within TIMEOUT cycles, err is raised and the unit also halts.
//
// Handshakes:
//   Memory side: mem_rd is a one-cycle request carrying mem_addr. mem_addr
//   stays equal to the PC while the read is outstanding. The reply is the
//   first cycle with mem_valid=1 while in WAIT_MEM, and mem_rdata is
//   captured in that cycle. mem_valid in any other state is ignored, so a
//   reply that arrives after a reset cannot be mistaken for a new one.
//   CPU side: load (one cycle) tells the CPU to latch instr; s (one cycle,
//   on the next cycle) starts it. The CPU drops w one cycle after s, so the
//   first WAIT_CPU cycle ignores w; from then on w=1 completes the
//   instruction.
//
// Parameters:
//   RESET_PC  PC value loaded by reset.
//   TIMEOUT   cycles allowed in WAIT_CPU before err (2..255).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   run        in   enables fetching
//   pc_set     in   load pc_val into the PC (IDLE only, beats run)
//   pc_val     in   [7:0]  new PC value
//   mem_rd     out  one-cycle read request
//   mem_addr   out  [7:0]  read address (current PC)
//   mem_rdata  in   [15:0] word returned by memory
//   mem_valid  in   mem_rdata valid this cycle
//   instr      out  [15:0] instruction register presented to the CPU
//   load       out  one-cycle strobe: CPU latches instr
//   s          out  one-cycle start strobe to the CPU
//   w          in   CPU is in its wait state
//   pc         out  [7:0]  current PC
//   retired    out  [15:0] completed instructions, saturating
//   halted     out  unit is in HALT
//   err        out  sticky CPU timeout flag
//   fsm_state  out  [2:0]  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        pc_set,
  input  logic [7:0]  pc_val,
  output logic        mem_rd,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] instr,
  output logic        load,
  output logic        s,
  input  logic        w,
  output logic [7:0]  pc,
  output logic [15:0] retired,
  output logic        halted,
  output logic        err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_MEM = 3'd2,
    LOAD     = 3'd3,
    START    = 3'd4,
    WAIT_CPU = 3'd5,
    HALT     = 3'd6
  } state_t;

  // Last WAIT_CPU cycle index in which w can still rescue the instruction.
  localparam logic [7:0] CPU_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cpu_cnt;     // cycles spent in WAIT_CPU, 0 = guard cycle
  logic        is_halt_op;
  logic        cpu_done;
  logic        cpu_timeout;

  assign is_halt_op  = (mem_rdata[15:13] == 3'b111);
  // w only counts once the guard cycle is past.
  assign cpu_done    = (state == WAIT_CPU) && (cpu_cnt != 8'd0) && w;
  assign cpu_timeout = (state == WAIT_CPU) && !cpu_done && (cpu_cnt == CPU_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        // pc_set wins: the PC is updated and fetching waits a cycle.
        if (!pc_set && run) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        state_nxt = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          state_nxt = is_halt_op ? HALT : LOAD;
        end
      end
      LOAD: begin
        state_nxt = START;
      end
      START: begin
        state_nxt = WAIT_CPU;
      end
      WAIT_CPU: begin
        // run is only consulted at instruction boundaries, so dropping it
        // mid-instruction lets the current one finish.
        if (cpu_done) begin
          state_nxt = run ? REQ : IDLE;
        end else if (cpu_timeout) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers: PC, instruction register, retire counter, error
  // flag and the WAIT_CPU cycle counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= 16'h0000;
      retired <= 16'h0000;
      err     <= 1'b0;
      cpu_cnt <= 8'd0;
    end else begin
      if ((state == IDLE) && pc_set) begin
        pc <= pc_val;
      end

      if ((state == WAIT_MEM) && mem_valid) begin
        instr <= mem_rdata;
        pc    <= pc + 8'd1;   // natural 8-bit wrap FF -> 00
      end

      if (state == START) begin
        cpu_cnt <= 8'd0;
      end else if ((state == WAIT_CPU) && (cpu_cnt != 8'hFF)) begin
        cpu_cnt <= cpu_cnt + 8'd1;
      end

      if (cpu_done && (retired != 16'hFFFF)) begin
        retired <= retired + 16'd1;
      end

      if (cpu_timeout) begin
        err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: pure decodes of the state, so each strobe lasts exactly one
  // cycle and no two strobes can coincide.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_rd    = 1'b0;
    load      = 1'b0;
    s         = 1'b0;
    halted    = 1'b0;
    mem_addr  = pc;
    fsm_state = state;
    unique case (state)
      REQ:     mem_rd = 1'b1;
      LOAD:    load   = 1'b1;
      START:   s      = 1'b1;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit (TIMEOUT=10, RESET_PC=0). Inputs are driven
// 1 time unit after the rising edge; outputs are read at the same point,
// after the edge has settled. A negedge monitor counts read requests and
// load pulses since the last reset and records any strobe-rule violation.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ      = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM = 3'd2;
  localparam logic [2:0] ST_LOAD     = 3'd3;
  localparam logic [2:0] ST_START    = 3'd4;
  localparam logic [2:0] ST_WAIT_CPU = 3'd5;
  localparam logic [2:0] ST_HALT     = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        run;
  logic        pc_set;
  logic [7:0]  pc_val;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] instr;
  logic        load;
  logic        s;
  logic        w;
  logic [7:0]  pc;
  logic [15:0] retired;
  logic        halted;
  logic        err;
  logic [2:0]  fsm_state;

  fetch_unit #(
    .RESET_PC (8'h00),
    .TIMEOUT  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .pc_set    (pc_set),
    .pc_val    (pc_val),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .instr     (instr),
    .load      (load),
    .s         (s),
    .w         (w),
    .pc        (pc),
    .retired   (retired),
    .halted    (halted),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int   rd_cnt = 0;
  int   load_cnt = 0;
  int   strobe_viol = 0;
  logic p_rd = 1'b0;
  logic p_load = 1'b0;
  logic p_s = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      rd_cnt   = 0;
      load_cnt = 0;
      p_rd     = 1'b0;
      p_load   = 1'b0;
      p_s      = 1'b0;
    end else begin
      if (mem_rd) rd_cnt++;
      if (load) load_cnt++;
      if ((int'(mem_rd) + int'(load) + int'(s)) > 1) strobe_viol++;
      if ((mem_rd && p_rd) || (load && p_load) || (s && p_s)) strobe_viol++;
      p_rd   = mem_rd;
      p_load = load;
      p_s    = s;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    pc_set    = 1'b0;
    pc_val    = 8'h00;
    mem_valid = 1'b0;
    mem_rdata = 16'h0000;
    w         = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Expects the unit in REQ; answers the read after one WAIT_MEM cycle.
  task automatic fetch_word(input logic [7:0] addr, input logic [15:0] data);
    check("fetch_rd", mem_rd, 1'b1);
    check("fetch_addr", mem_addr, addr);
    step();
    check("fetch_hold_addr", mem_addr, addr);
    mem_valid = 1'b1;
    mem_rdata = data;
    step();
    mem_valid = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    do_reset();

    // Reset state
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instr, 16'h0000);
    check("rst_retired", retired, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_strobes", {mem_rd, load, s}, 3'b000);

    // Basic fetch: 2-cycle memory, CPU holds w low for 3 cycles
    run = 1'b1;
    step();
    check("b_req_state", fsm_state, ST_REQ);
    check("b_req_rd", mem_rd, 1'b1);
    check("b_req_addr", mem_addr, 8'h00);
    step();
    check("b_wm_state", fsm_state, ST_WAIT_MEM);
    check("b_wm_rd", mem_rd, 1'b0);
    step();
    check("b_wm2_state", fsm_state, ST_WAIT_MEM);
    mem_valid = 1'b1;
    mem_rdata = 16'hD105;
    step();
    mem_valid = 1'b0;
    check("b_load", load, 1'b1);
    check("b_load_s", s, 1'b0);
    check("b_instr", instr, 16'hD105);
    check("b_pc", pc, 8'h01);
    step();
    check("b_s", s, 1'b1);
    check("b_s_load", load, 1'b0);
    step();
    check("b_guard_state", fsm_state, ST_WAIT_CPU);
    step();
    check("b_guard_ignored", fsm_state, ST_WAIT_CPU);
    w = 1'b0;
    step();
    step();
    step();
    check("b_busy_retired", retired, 16'd0);
    w = 1'b1;
    step();
    check("b_retired", retired, 16'd1);
    check("b_next_rd", mem_rd, 1'b1);
    check("b_next_addr", mem_addr, 8'h01);
    // mem_valid while in REQ must be ignored
    mem_valid = 1'b1;
    mem_rdata = 16'hE000;
    step();
    mem_valid = 1'b0;
    check("b_ign_state", fsm_state, ST_WAIT_MEM);
    check("b_ign_instr", instr, 16'hD105);
    check("b_ign_pc", pc, 8'h01);

    // Halt word
    do_reset();
    run = 1'b1;
    step();
    fetch_word(8'h00, 16'hE000);
    check("h_halted", halted, 1'b1);
    check("h_pc", pc, 8'h01);
    check("h_err", err, 1'b0);
    pc_set = 1'b1;
    pc_val = 8'h55;
    repeat (20) step();
    pc_set = 1'b0;
    check("h_still_halted", halted, 1'b1);
    check("h_no_load", load_cnt, 0);
    check("h_one_rd", rd_cnt, 1);
    check("h_pc_kept", pc, 8'h01);

    // PC wrap-around, and pc_set beating run in the same cycle
    do_reset();
    pc_set = 1'b1;
    pc_val = 8'hFF;
    run    = 1'b1;
    step();
    check("wr_prio_state", fsm_state, ST_IDLE);
    check("wr_prio_pc", pc, 8'hFF);
    pc_set = 1'b0;
    step();
    fetch_word(8'hFF, 16'h1234);
    check("wr_pc", pc, 8'h00);
    check("wr_load_state", fsm_state, ST_LOAD);
    step();
    step();
    step();
    step();
    check("wr_next_rd", mem_rd, 1'b1);
    check("wr_next_addr", mem_addr, 8'h00);
    check("wr_retired", retired, 16'd1);

    // run dropped during WAIT_CPU
    do_reset();
    run = 1'b1;
    step();
    fetch_word(8'h00, 16'h2222);
    step();
    step();
    run = 1'b0;
    w   = 1'b0;
    step();
    step();
    w = 1'b1;
    step();
    check("rd_idle", fsm_state, ST_IDLE);
    check("rd_retired", retired, 16'd1);
    repeat (5) step();
    check("rd_no_new_rd", rd_cnt, 1);
    check("rd_still_idle", fsm_state, ST_IDLE);

    // CPU timeout (TIMEOUT=10 cycles in WAIT_CPU)
    do_reset();
    run = 1'b1;
    step();
    fetch_word(8'h00, 16'h1111);
    step();
    w = 1'b0;
    step();
    check("to_enter", fsm_state, ST_WAIT_CPU);
    repeat (9) step();
    check("to_last_state", fsm_state, ST_WAIT_CPU);
    check("to_last_err", err, 1'b0);
    step();
    check("to_err", err, 1'b1);
    check("to_halted", halted, 1'b1);
    check("to_retired", retired, 16'd0);
    do_reset();
    check("to_rst_err", err, 1'b0);
    check("to_rst_halted", halted, 1'b0);

    // Reset with a read outstanding, late mem_valid afterwards
    run = 1'b1;
    step();
    fetch_word(8'h00, 16'h3333);
    step();
    step();
    step();
    step();
    check("mr_second_addr", mem_addr, 8'h01);
    step();
    check("mr_wait_mem", fsm_state, ST_WAIT_MEM);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    run       = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 16'hABCD;
    step();
    mem_valid = 1'b0;
    check("mr_state", fsm_state, ST_IDLE);
    check("mr_instr", instr, 16'h0000);
    check("mr_pc", pc, 8'h00);
    step();
    check("mr_no_load", load_cnt, 0);
    check("mr_still_idle", fsm_state, ST_IDLE);

    check("strobe_rules", strobe_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
